// File: rtl/md5_ctrl_pkg.sv
// Shared constants for the MD5 cracker multi-unit controller.
// Register word addresses, block version and unit-count ceiling.
// No logic; imported by the controller top and its per-unit tracker.
package md5_ctrl_pkg;

    localparam logic [2:0] ADDR_RESET  = 3'd0;
    localparam logic [2:0] ADDR_START  = 3'd1;
    localparam logic [2:0] ADDR_DONE   = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd3;
    localparam logic [2:0] ADDR_ENABLE = 3'd4;
    localparam logic [2:0] ADDR_CYCLES = 3'd5;
    localparam logic [2:0] ADDR_INFO   = 3'd6;

    localparam logic [7:0] VERSION   = 8'h02;
    localparam int         MAX_UNITS = 32;

endpackage

// File: rtl/md5_unit_tracker.sv
// Per-unit state: busy flag, done edge detect, sticky done and start/reset pulses.
// Pulses and state update one cycle after the request.
// No backpressure; a start request is dropped while the unit is busy.
module md5_unit_tracker (
    input  logic clk,
    input  logic reset_n,
    input  logic armed,
    input  logic rst_req,
    input  logic start_req,
    input  logic clr_req,
    input  logic done_in,
    output logic start_acc,
    output logic md5_start,
    output logic md5_reset,
    output logic busy,
    output logic done_sticky
);

    logic done_prev;
    logic done_edge;

    // Busy is sampled before this cycle's update, so a coinciding done edge cannot admit a start.
    assign start_acc = start_req & ~busy;
    assign done_edge = armed & done_in & ~done_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_prev   <= 1'b0;
            md5_start   <= 1'b0;
            md5_reset   <= 1'b0;
            busy        <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            done_prev <= done_in;
            md5_start <= start_acc;
            md5_reset <= rst_req;

            if (rst_req)
                busy <= 1'b0;
            else if (start_acc)
                busy <= 1'b1;
            else if (done_edge)
                busy <= 1'b0;

            // A reset aborts silently; a fresh edge beats a same-cycle clear.
            if (rst_req)
                done_sticky <= 1'b0;
            else if (done_edge)
                done_sticky <= 1'b1;
            else if (clr_req)
                done_sticky <= 1'b0;
        end
    end

endmodule

// File: rtl/md5_multicontrol.sv
// Avalon-MM controller for NUM_UNITS MD5 cracker units: start/reset/done/irq/cycle count.
// Read data one cycle after avs_read; unit pulses one cycle after the write.
// No wait states; a read coinciding with a write is dropped.
module md5_multicontrol
    import md5_ctrl_pkg::*;
#(
    parameter int NUM_UNITS = 8,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           avs_address,
    input  logic [31:0]          avs_writedata,
    input  logic                 avs_write,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic [NUM_UNITS-1:0] md5_start,
    output logic [NUM_UNITS-1:0] md5_reset,
    input  logic [NUM_UNITS-1:0] md5_done,
    output logic                 irq
);

    logic [NUM_UNITS-1:0] wdat;
    logic [NUM_UNITS-1:0] irq_en;
    logic [NUM_UNITS-1:0] enable;
    logic [NUM_UNITS-1:0] busy;
    logic [NUM_UNITS-1:0] done_sticky;
    logic [NUM_UNITS-1:0] start_acc;
    logic [CNT_W-1:0]     cycles;
    logic [31:0]          rd_mux;
    logic                 armed;
    logic                 wr_reset;
    logic                 wr_start;
    logic                 wr_done;
    logic                 unused_wdat;

    assign wdat        = avs_writedata[NUM_UNITS-1:0];
    assign unused_wdat = ^avs_writedata;

    assign wr_reset = avs_write && (avs_address == ADDR_RESET);
    assign wr_start = avs_write && (avs_address == ADDR_START);
    assign wr_done  = avs_write && (avs_address == ADDR_DONE);

    // Suppresses edge detection on the first clock after reset so a level already high is not a done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            armed <= 1'b0;
        else
            armed <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= '0;
            enable <= '1;
        end else if (avs_write) begin
            if (avs_address == ADDR_IRQ_EN)
                irq_en <= wdat;
            if (avs_address == ADDR_ENABLE)
                enable <= wdat;
        end
    end

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
        md5_unit_tracker u_trk (
            .clk         (clk),
            .reset_n     (reset_n),
            .armed       (armed),
            .rst_req     (wr_reset & wdat[gi]),
            .start_req   (wr_start & wdat[gi] & enable[gi]),
            .clr_req     (wr_done & wdat[gi]),
            .done_in     (md5_done[gi]),
            .start_acc   (start_acc[gi]),
            .md5_start   (md5_start[gi]),
            .md5_reset   (md5_reset[gi]),
            .busy        (busy[gi]),
            .done_sticky (done_sticky[gi])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cycles <= '0;
        else if (|start_acc)
            cycles <= '0;
        else if ((|busy) && (cycles != '1))
            cycles <= cycles + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= |(done_sticky & irq_en);
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_START:  rd_mux = 32'(busy);
            ADDR_DONE:   rd_mux = 32'(done_sticky);
            ADDR_IRQ_EN: rd_mux = 32'(irq_en);
            ADDR_ENABLE: rd_mux = 32'(enable);
            ADDR_CYCLES: rd_mux = 32'(cycles);
            ADDR_INFO:   rd_mux = {16'h0000, VERSION, 8'(NUM_UNITS)};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else if (avs_read && !avs_write) begin
            avs_readdata      <= rd_mux;
            avs_readdatavalid <= 1'b1;
        end else begin
            avs_readdatavalid <= 1'b0;
        end
    end

endmodule

// File: doc/md5_multicontrol.md
MD5_MULTICONTROL -- requirements
Module: md5_multicontrol

Interface
REQ-001 Parameter NUM_UNITS, default 8, number of MD5 cracker units controlled; legal range 1..32.
REQ-002 Parameter CNT_W, default 32, width of the run-cycle counter; legal range 8..32.
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 avs_address  input  3  Avalon-MM word address.
REQ-006 avs_writedata  input  32  write data.
REQ-007 avs_write  input  1  write strobe.
REQ-008 avs_read  input  1  read strobe.
REQ-009 avs_readdata  output  32  registered read data.
REQ-010 avs_readdatavalid  output  1  high one cycle when avs_readdata is valid.
REQ-011 md5_start  output  NUM_UNITS  per-unit one-cycle start pulse.
REQ-012 md5_reset  output  NUM_UNITS  per-unit one-cycle reset pulse.
REQ-013 md5_done  input  NUM_UNITS  per-unit done level, synchronous to clk.
REQ-014 irq  output  1  registered level interrupt.

Function
REQ-015 Register map: 0 RESET (W pulse, R 0); 1 START (W pulse, R busy mask); 2 DONE (R sticky done, W1C); 3 IRQ_EN (RW); 4 ENABLE (RW); 5 CYCLES (R); 6 INFO (R, [7:0]=NUM_UNITS, [15:8]=8'h02); 7 reads 0, writes ignored.
REQ-016 Write data bits at or above NUM_UNITS ignored; read bits at or above NUM_UNITS (registers 0-4) return 0.
REQ-017 Write to RESET drives md5_reset[i]=1 for exactly the cycle after the write, for each set bit i, regardless of ENABLE; also clears busy[i] and done_sticky[i] that cycle.
REQ-018 Write to START accepts bit i only if writedata[i] & ENABLE[i] & ~busy[i]; accepted units get md5_start[i]=1 for exactly the cycle after the write and busy[i] set; rejected bits have no effect.
REQ-019 Done detection on md5_done[i] rising edge (registered previous value); edge sets done_sticky[i] and clears busy[i].
REQ-020 Done edge and DONE W1C of same bit in same cycle: set wins.
REQ-021 Done edge and START of same busy unit in same cycle: start rejected (busy sampled pre-update).
REQ-022 RESET and START writes never coincide (one write per cycle); RESET of a unit while busy aborts it with no done_sticky set.
REQ-023 CYCLES cleared to 0 on any cycle with at least one accepted start; otherwise increments each cycle any busy bit is set; saturates at all-ones; holds when idle.
REQ-024 irq registered: irq = OR(done_sticky & IRQ_EN), one-cycle latency from sticky/enable change.
REQ-025 Read latency exactly 1: avs_readdata and avs_readdatavalid update the cycle after avs_read; avs_readdata holds otherwise.
REQ-026 avs_write and avs_read both high: write performed, read ignored, no readdatavalid.
REQ-027 md5_start and md5_reset are 0 in every cycle not following an accepted write.

Reset
REQ-028 reset_n low asynchronously forces: md5_start=0, md5_reset=0, busy=0, done_sticky=0, done_prev=0, IRQ_EN=0, ENABLE=all ones (NUM_UNITS bits), CYCLES=0, avs_readdata=0, avs_readdatavalid=0, irq=0.
REQ-029 After reset_n deasserts, a unit whose md5_done is already high does not produce a done edge until md5_done falls and rises again (done_prev loads md5_done on first clock).

Structure
REQ-030 Shared package md5_ctrl_pkg holds register address constants, VERSION (8'h02), and the maximum unit count (32).
REQ-031 One sub-module md5_unit_tracker, instantiated NUM_UNITS times, holds busy, done_prev, done_sticky and pulse generation for one unit; bus decode, CYCLES, irq and read mux stay in the top.

Verification
REQ-032 Reset, read INFO -> readdata=32'h0000_0208 one cycle later with readdatavalid; read ENABLE -> 32'h0000_00FF.
REQ-033 Write START=0x05 -> md5_start=0x05 for one cycle, busy read 0x05; raise md5_done[0] after 10 cycles -> DONE=0x01, busy=0x04, CYCLES=10.
REQ-034 ENABLE=0xFE, write START=0x03 -> only md5_start[1] pulses; second START=0x02 while busy -> no pulse.
REQ-035 IRQ_EN=0x01, done edge unit 0 -> irq high next cycle; write DONE=0x01 -> irq low; W1C coinciding with new edge -> DONE bit stays 1.
REQ-036 START unit 3, write RESET=0x08 mid-run -> md5_reset[3] one-cycle pulse, busy=0, DONE bit 3 stays 0; assert reset_n mid-run -> all outputs zero immediately.
